// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution: compares the IF prediction carried into ID with the resolved outcome,
// drives flush/redirect/notFlushed, a one-cycle recovery flag and saturating performance counters.
module branch_resolve_unit #(
   parameter logic [6:0] BRANCH_OP = 7'b1100011,
   parameter int         CNT_W     = 32
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             IF_predTaken,
   input  logic [63:0]      IF_predTarget,
   input  logic             IF_ID_stall,
   input  logic [31:0]      ID_INST,
   input  logic [63:0]      ID_PC,
   input  logic             ID_actualTaken,
   input  logic [63:0]      ID_actualTarget,
   output logic             flush,
   output logic [63:0]      redirectPC,
   output logic             notFlushed,
   output logic             recovering,
   output logic [CNT_W-1:0] branchCount,
   output logic [CNT_W-1:0] mispredictCount
);

   typedef enum logic {IDLE, RECOVER} state_t;

   state_t      state_q, state_d;
   logic        pred_taken_q;
   logic [63:0] pred_target_q;
   logic        shadow_valid_q;
   logic        is_branch;
   logic        mis;

   always_comb begin
      state_d    = state_q;
      recovering = 1'b0;
      is_branch  = 1'b0;
      mis        = 1'b0;
      flush      = 1'b0;
      redirectPC = 64'd0;
      case (state_q)
         IDLE: begin
            is_branch = (ID_INST[6:0] == BRANCH_OP) & shadow_valid_q;
            mis = is_branch & ((pred_taken_q != ID_actualTaken) |
                               (pred_taken_q & ID_actualTaken & (pred_target_q != ID_actualTarget)));
            flush = mis;
            if (mis) state_d = RECOVER;
         end
         RECOVER: begin
            // ID holds a bubble: nothing resolves and stall cannot stretch this state
            recovering = 1'b1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (flush)
         redirectPC = ID_actualTaken ? ID_actualTarget : ID_PC + 64'd4;
      notFlushed = ~flush;
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Flush wins over stall: the squashed IF slot must not leave a stale prediction behind
   always_ff @(posedge clk) begin
      if (!arst_n || flush) begin
         pred_taken_q   <= 1'b0;
         pred_target_q  <= 64'd0;
         shadow_valid_q <= 1'b0;
      end else if (!IF_ID_stall) begin
         pred_taken_q   <= IF_predTaken;
         pred_target_q  <= IF_predTarget;
         shadow_valid_q <= 1'b1;
      end
   end

   // A branch held by stall is counted once, on the edge that lets it leave ID
   always_ff @(posedge clk) begin
      if (!arst_n) begin
         branchCount     <= '0;
         mispredictCount <= '0;
      end else begin
         if (is_branch && !IF_ID_stall && !(&branchCount))
            branchCount <= branchCount + CNT_W'(1);
         if (mis && !(&mispredictCount))
            mispredictCount <= mispredictCount + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed vectors with hand-computed expectations; a driver queues expected responses and a
// negedge monitor pops and compares them against the DUT each checked cycle.
module tb_branch_resolve_unit;

   localparam int CNT_W = 3;
   localparam logic [31:0] BEQ = 32'h0000_0063;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic             clk;
   logic             arst_n;
   logic             IF_predTaken;
   logic [63:0]      IF_predTarget;
   logic             IF_ID_stall;
   logic [31:0]      ID_INST;
   logic [63:0]      ID_PC;
   logic             ID_actualTaken;
   logic [63:0]      ID_actualTarget;
   logic             flush;
   logic [63:0]      redirectPC;
   logic             notFlushed;
   logic             recovering;
   logic [CNT_W-1:0] branchCount;
   logic [CNT_W-1:0] mispredictCount;

   branch_resolve_unit #(.BRANCH_OP(7'b1100011), .CNT_W(CNT_W)) dut (
      .clk(clk), .arst_n(arst_n),
      .IF_predTaken(IF_predTaken), .IF_predTarget(IF_predTarget), .IF_ID_stall(IF_ID_stall),
      .ID_INST(ID_INST), .ID_PC(ID_PC), .ID_actualTaken(ID_actualTaken), .ID_actualTarget(ID_actualTarget),
      .flush(flush), .redirectPC(redirectPC), .notFlushed(notFlushed), .recovering(recovering),
      .branchCount(branchCount), .mispredictCount(mispredictCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n, stall, pt;
      logic [63:0] ptgt;
      logic [31:0] inst;
      logic [63:0] pc;
      logic        at;
      logic [63:0] atgt;
      logic        chk;
      logic        fl;
      logic [63:0] rpc;
      logic        nf, rec;
      int          bc, mc;
   } vec_t;

   typedef struct {
      int          idx;
      logic        fl;
      logic [63:0] rpc;
      logic        nf, rec;
      int          bc, mc;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   task automatic add(input logic rst_n, stall, pt, input logic [63:0] ptgt, input logic [31:0] inst,
                      input logic [63:0] pc, input logic at, input logic [63:0] atgt, input logic chk,
                      input logic fl, input logic [63:0] rpc, input logic nf, rec, input int bc, mc);
      vec_t v;
      v.rst_n = rst_n; v.stall = stall; v.pt = pt; v.ptgt = ptgt; v.inst = inst; v.pc = pc;
      v.at = at; v.atgt = atgt; v.chk = chk; v.fl = fl; v.rpc = rpc; v.nf = nf; v.rec = rec;
      v.bc = bc; v.mc = mc;
      vecs.push_back(v);
   endtask

   task automatic cmp(input int idx, input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL cyc%0d %s: got 0x%0h expected 0x%0h", idx, name, act, expv);
      end
   endtask

   // monitor: outputs are combinational/registered and valid every cycle, sampled on the falling edge
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         cmp(e.idx, "flush", {63'd0, flush}, {63'd0, e.fl});
         cmp(e.idx, "redirectPC", redirectPC, e.rpc);
         cmp(e.idx, "notFlushed", {63'd0, notFlushed}, {63'd0, e.nf});
         cmp(e.idx, "recovering", {63'd0, recovering}, {63'd0, e.rec});
         cmp(e.idx, "branchCount", 64'(branchCount), 64'(e.bc));
         cmp(e.idx, "mispredictCount", 64'(mispredictCount), 64'(e.mc));
      end
   end

   initial begin
      //   rst stl pt ptgt      inst pc                      at atgt     chk fl rpc      nf rec bc mc
      add(0, 0, 0, 64'h0,   NOP, 64'h0,                  0, 64'h0,   0,  0, 64'h0,   1, 0,  0, 0); // 0 reset
      add(0, 0, 0, 64'h0,   NOP, 64'h0,                  0, 64'h0,   0,  0, 64'h0,   1, 0,  0, 0); // 1 reset
      add(1, 0, 1, 64'h100, NOP, 64'h0,                  0, 64'h0,   1,  0, 64'h0,   1, 0,  0, 0); // 2 non-branch
      add(1, 0, 0, 64'h0,   BEQ, 64'h40,                 1, 64'h100, 1,  0, 64'h0,   1, 0,  0, 0); // 3 correct taken
      add(1, 0, 1, 64'h200, BEQ, 64'h40,                 1, 64'h80,  1,  1, 64'h80,  0, 0,  1, 0); // 4 pred NT, actual T
      add(1, 0, 1, 64'h200, BEQ, 64'h40,                 1, 64'h80,  1,  0, 64'h0,   1, 1,  2, 1); // 5 recover bubble
      add(1, 0, 1, 64'h200, NOP, 64'h0,                  0, 64'h0,   1,  0, 64'h0,   1, 0,  2, 1); // 6
      add(1, 0, 0, 64'h0,   BEQ, 64'h40,                 0, 64'h0,   1,  1, 64'h44,  0, 0,  2, 1); // 7 pred T, actual NT
      add(1, 0, 1, 64'h200, NOP, 64'h0,                  0, 64'h0,   1,  0, 64'h0,   1, 1,  3, 2); // 8
      add(1, 0, 0, 64'h0,   BEQ, 64'h40,                 1, 64'h208, 1,  1, 64'h208, 0, 0,  3, 2); // 9 target mismatch
      add(1, 0, 0, 64'h0,   NOP, 64'h0,                  0, 64'h0,   1,  0, 64'h0,   1, 1,  4, 3); // 10
      add(1, 1, 1, 64'h300, BEQ, 64'h40,                 0, 64'h0,   1,  0, 64'h0,   1, 0,  4, 3); // 11 stalled branch
      add(1, 1, 1, 64'h300, BEQ, 64'h40,                 0, 64'h0,   1,  0, 64'h0,   1, 0,  4, 3); // 12
      add(1, 1, 1, 64'h300, BEQ, 64'h40,                 0, 64'h0,   1,  0, 64'h0,   1, 0,  4, 3); // 13
      add(1, 0, 0, 64'h0,   BEQ, 64'h40,                 0, 64'h0,   1,  0, 64'h0,   1, 0,  4, 3); // 14 release
      add(1, 0, 1, 64'h500, NOP, 64'h0,                  0, 64'h0,   1,  0, 64'h0,   1, 0,  5, 3); // 15 counted once
      add(1, 1, 1, 64'h10,  BEQ, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0,  1,  1, 64'h0,   0, 0,  5, 3); // 16 wrap, stall
      add(1, 1, 1, 64'h10,  NOP, 64'h0,                  0, 64'h0,   1,  0, 64'h0,   1, 1,  5, 4); // 17 stall in RECOVER
      add(1, 0, 1, 64'h10,  NOP, 64'h0,                  0, 64'h0,   1,  0, 64'h0,   1, 0,  5, 4); // 18
      add(1, 0, 1, 64'h10,  BEQ, 64'h0,                  0, 64'h0,   1,  1, 64'h4,   0, 0,  5, 4); // 19
      add(1, 0, 1, 64'h10,  NOP, 64'h0,                  0, 64'h0,   1,  0, 64'h0,   1, 1,  6, 5); // 20
      add(1, 0, 1, 64'h10,  BEQ, 64'h0,                  0, 64'h0,   1,  1, 64'h4,   0, 0,  6, 5); // 21
      add(1, 0, 1, 64'h10,  NOP, 64'h0,                  0, 64'h0,   1,  0, 64'h0,   1, 1,  7, 6); // 22
      add(1, 0, 1, 64'h10,  BEQ, 64'h0,                  0, 64'h0,   1,  1, 64'h4,   0, 0,  7, 6); // 23
      add(1, 0, 1, 64'h10,  NOP, 64'h0,                  0, 64'h0,   1,  0, 64'h0,   1, 1,  7, 7); // 24
      add(1, 0, 1, 64'h10,  BEQ, 64'h0,                  0, 64'h0,   1,  1, 64'h4,   0, 0,  7, 7); // 25 saturate
      add(1, 0, 1, 64'h10,  NOP, 64'h0,                  0, 64'h0,   1,  0, 64'h0,   1, 1,  7, 7); // 26
      add(0, 0, 1, 64'h10,  BEQ, 64'h0,                  0, 64'h0,   1,  1, 64'h4,   0, 0,  7, 7); // 27 reset vs mis
      add(1, 0, 1, 64'h10,  NOP, 64'h0,                  0, 64'h0,   1,  0, 64'h0,   1, 0,  0, 0); // 28
      add(1, 0, 1, 64'h10,  BEQ, 64'h0,                  0, 64'h0,   1,  1, 64'h4,   0, 0,  0, 0); // 29
      add(0, 0, 1, 64'h10,  NOP, 64'h0,                  0, 64'h0,   1,  0, 64'h0,   1, 1,  1, 1); // 30 reset in RECOVER
      add(1, 0, 0, 64'h0,   NOP, 64'h0,                  0, 64'h0,   1,  0, 64'h0,   1, 0,  0, 0); // 31

      arst_n = 0; IF_predTaken = 0; IF_predTarget = 0; IF_ID_stall = 0;
      ID_INST = NOP; ID_PC = 0; ID_actualTaken = 0; ID_actualTarget = 0;
      foreach (vecs[i]) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         arst_n = vecs[i].rst_n; IF_ID_stall = vecs[i].stall;
         IF_predTaken = vecs[i].pt; IF_predTarget = vecs[i].ptgt;
         ID_INST = vecs[i].inst; ID_PC = vecs[i].pc;
         ID_actualTaken = vecs[i].at; ID_actualTarget = vecs[i].atgt;
         if (vecs[i].chk) begin
            exp_t e;
            e.idx = i; e.fl = vecs[i].fl; e.rpc = vecs[i].rpc; e.nf = vecs[i].nf;
            e.rec = vecs[i].rec; e.bc = vecs[i].bc; e.mc = vecs[i].mc;
            sb.push_back(e);
         end
      end
      begin
         int guard = 0;
         while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
         end
         if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
